// File: rtl/frame_write_sequencer_pkg.sv
// Shared defaults and state encoding for the frame write sequencer.
// Default screen is 320x480 with 3-bit colour.
package frame_write_sequencer_pkg;

  localparam int FWS_SCREEN_W = 320;
  localparam int FWS_SCREEN_H = 480;
  localparam int FWS_PIXELS   = FWS_SCREEN_W * FWS_SCREEN_H;
  localparam int FWS_DATA_W   = 3;
  localparam int FWS_ADDR_W   = 19;
  localparam int FWS_NUM_CH   = 2;
  localparam int FWS_IDX_W    = 10;
  localparam int FWS_TIMEOUT  = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } fws_state_t;

  // Channel-index width; a single channel still needs one bit.
  function automatic int fws_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_write_sequencer_fb_write_mux.sv
// Registered frame-buffer write port: selects the active channel's bus,
// or the clear-pass write when the override is asserted.
module fb_write_mux #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3,
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*ADDR_W-1:0] i_ch_waddr,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_wdata,
  input  logic [NUM_CH-1:0]        i_ch_wenable,
  input  logic [CH_W-1:0]          i_sel,
  input  logic                     i_en,
  input  logic                     i_ovr,
  input  logic [ADDR_W-1:0]        i_ovr_addr,
  input  logic [DATA_W-1:0]        i_ovr_data,
  output logic [ADDR_W-1:0]        o_waddr,
  output logic [DATA_W-1:0]        o_wdata,
  output logic                     o_wenable
);

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_wen;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_wen  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_sel == CH_W'(c)) begin
        w_addr = i_ch_waddr[c*ADDR_W +: ADDR_W];
        w_data = i_ch_wdata[c*DATA_W +: DATA_W];
        w_wen  = i_ch_wenable[c];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_waddr   <= '0;
      o_wdata   <= '0;
      o_wenable <= 1'b0;
    end else if (i_ovr) begin
      o_waddr   <= i_ovr_addr;
      o_wdata   <= i_ovr_data;
      o_wenable <= 1'b1;
    end else begin
      o_waddr   <= w_addr;
      o_wdata   <= w_data;
      o_wenable <= i_en & w_wen;
    end
  end

endmodule

// File: rtl/frame_write_sequencer.sv
// Frame write sequencer: clears the frame buffer, then runs each enabled
// writer channel through its items in channel order, one frame at a time.
module frame_write_sequencer
  import frame_write_sequencer_pkg::*;
#(
  parameter int               ADDR_W     = FWS_ADDR_W,
  parameter int               DATA_W     = FWS_DATA_W,
  parameter int               NUM_CH     = FWS_NUM_CH,
  parameter int               PIXELS     = FWS_PIXELS,
  parameter int               IDX_W      = FWS_IDX_W,
  parameter logic [DATA_W-1:0] CLEAR_DATA = '0,
  parameter int               TIMEOUT    = FWS_TIMEOUT,
  localparam int              CH_W       = fws_ch_w(NUM_CH)
)(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*IDX_W-1:0]  ch_items,
  output logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_finish,
  input  logic [NUM_CH*ADDR_W-1:0] ch_waddr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_wenable,
  output logic [IDX_W-1:0]         item_index,
  output logic [CH_W-1:0]          active_ch,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_wenable,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(NUM_CH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  fws_state_t              r_state;
  logic [ADDR_W-1:0]       r_clr_cnt;
  logic [PTR_W-1:0]        r_ptr;
  logic [TO_W-1:0]         r_wait_cnt;
  logic [NUM_CH-1:0]       r_en_lat;
  logic [NUM_CH*IDX_W-1:0] r_items_lat;
  logic [IDX_W-1:0]        r_item_idx;
  logic [CH_W-1:0]         r_active;
  logic [NUM_CH-1:0]       r_start;
  logic                    r_frame_done;
  logic                    r_busy;
  logic                    r_timeout;

  logic                    w_sel_found;
  logic [CH_W-1:0]         w_sel_ch;
  logic [IDX_W-1:0]        w_cur_count;
  logic                    w_cur_fin;
  logic                    w_timeout;
  logic [IDX_W-1:0]        w_next_idx;
  logic                    w_last;
  logic                    w_fwd;

  // Descending walk so the lowest qualifying channel at or above the pointer wins.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_ch    = '0;
    w_cur_count = '0;
    w_cur_fin   = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (c >= int'(r_ptr) && r_en_lat[c] && r_items_lat[c*IDX_W +: IDX_W] != '0) begin
        w_sel_found = 1'b1;
        w_sel_ch    = CH_W'(c);
      end
      if (r_active == CH_W'(c)) begin
        w_cur_count = r_items_lat[c*IDX_W +: IDX_W];
        w_cur_fin   = ch_finish[c];
      end
    end
  end

  assign w_timeout  = (r_state == ST_WAIT) && !w_cur_fin && (r_wait_cnt == TO_W'(TIMEOUT - 1));
  assign w_next_idx = r_item_idx + 1'b1;
  assign w_last     = (w_next_idx == w_cur_count);
  assign w_fwd      = (r_state == ST_WAIT) && !w_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_clr_cnt    <= '0;
      r_ptr        <= '0;
      r_wait_cnt   <= '0;
      r_en_lat     <= '0;
      r_items_lat  <= '0;
      r_item_idx   <= '0;
      r_active     <= '0;
      r_start      <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_start      <= '0;
      r_frame_done <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy    <= 1'b1;
          r_clr_cnt <= '0;
          r_state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (r_clr_cnt == ADDR_W'(PIXELS - 1)) begin
            r_ptr       <= '0;
            r_en_lat    <= ch_enable;
            r_items_lat <= ch_items;
            r_state     <= ST_SCAN;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_SCAN: begin
          r_item_idx <= '0;
          if (w_sel_found) begin
            r_active <= w_sel_ch;
            r_start  <= NUM_CH'(1) << w_sel_ch;
            r_state  <= ST_ISSUE;
          end else begin
            r_frame_done <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_cur_fin || w_timeout) begin
            r_timeout  <= w_timeout;
            r_item_idx <= w_next_idx;
            if (w_last) begin
              r_ptr   <= PTR_W'(r_active) + 1'b1;
              r_state <= ST_SCAN;
            end else begin
              r_start <= NUM_CH'(1) << r_active;
              r_state <= ST_ISSUE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (clear_req) begin
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end else begin
            r_ptr       <= '0;
            r_en_lat    <= ch_enable;
            r_items_lat <= ch_items;
            r_state     <= ST_SCAN;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fb_write_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_mux (
    .clock        (clock),
    .reset        (reset),
    .i_ch_waddr   (ch_waddr),
    .i_ch_wdata   (ch_wdata),
    .i_ch_wenable (ch_wenable),
    .i_sel        (r_active),
    .i_en         (w_fwd),
    .i_ovr        (r_state == ST_CLEAR),
    .i_ovr_addr   (r_clr_cnt),
    .i_ovr_data   (CLEAR_DATA),
    .o_waddr      (mem_waddr),
    .o_wdata      (mem_wdata),
    .o_wenable    (mem_wenable)
  );

  assign ch_start    = r_start;
  assign item_index  = r_item_idx;
  assign active_ch   = r_active;
  assign frame_done  = r_frame_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout;

endmodule
